// File: rtl/icache_data_nway_if.sv
// Bundle of the fetch-read and refill-beat signals between the icache
// tag/LRU controller, the AXI read master and the data array.
// master: the side issuing reads and beats; slave: the data array.
interface icache_data_nway_if #(
  parameter int WAYS      = 2,
  parameter int BEAT_BITS = 64,
  parameter int ADDR_W    = 64
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Fetch read channel
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [WAYS-1:0]   rd_hit;
  logic              rd_data_valid;
  logic [31:0]       rd_data;

  // Refill beat channel
  logic                 refill_valid;
  logic                 refill_ready;
  logic [BEAT_BITS-1:0] refill_data;
  logic                 refill_last;
  logic [ADDR_W-1:0]    refill_addr;
  logic [WAY_W-1:0]     refill_way;
  logic                 refill_done;
  logic                 refill_err;

  modport master (
    output rd_valid, rd_addr, rd_hit,
    output refill_valid, refill_data, refill_last, refill_addr, refill_way,
    input  rd_ready, rd_data_valid, rd_data,
    input  refill_ready, refill_done, refill_err
  );

  modport slave (
    input  rd_valid, rd_addr, rd_hit,
    input  refill_valid, refill_data, refill_last, refill_addr, refill_way,
    output rd_ready, rd_data_valid, rd_data,
    output refill_ready, refill_done, refill_err
  );
endinterface

// File: rtl/icache_data_nway.sv
// N-way instruction-cache data array. Serves one-cycle-latency word reads
// from the way chosen by the external tag compare, and assembles a line from
// successive AXI R beats before committing it to the victim way in one cycle.
module icache_data_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  parameter int BEAT_BITS  = 64,
  parameter int ADDR_W     = 64
) (
  input logic clk,
  input logic rst,
  icache_data_nway_if.slave bus
);
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(SETS);
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int BEATS      = LINE_BITS / BEAT_BITS;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORDS      = LINE_BITS / 32;
  localparam int WORD_IDX_W = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                          state_q, state_d;
  logic [BEAT_IDX_W-1:0]           cnt_q, cnt_d;
  logic                            refill_err_q, refill_err_d;
  logic [BEATS-1:0][BEAT_BITS-1:0] line_buf_q;
  logic [INDEX_W-1:0]              fill_index_q;
  logic [WAY_W-1:0]                fill_way_q;

  logic [LINE_BITS-1:0] mem [WAYS][SETS];
  logic [LINE_BITS-1:0] line_q [WAYS];
  logic [WAYS-1:0]      hit_q;
  logic [OFFSET_W-1:0]  off_q;
  logic                 rd_data_valid_q;

  logic                       rd_accept;
  logic                       beat_accept;
  logic                       beat_is_final;
  logic                       write_en;
  logic [BEAT_IDX_W-1:0]      beat_idx;
  logic [INDEX_W-1:0]         rd_index;
  logic [WAY_W-1:0]           sel_way;
  logic [WORDS-1:0][31:0]     sel_line;
  logic [WORD_IDX_W-1:0]      word_idx;
  logic [31:0]                rd_word;
  logic                       unused_addr_bits;

  // The array cannot accept a read or a beat while it is busy committing a line.
  assign bus.rd_ready      = (state_q != WRITE);
  assign bus.refill_ready  = (state_q != WRITE);
  assign bus.refill_done   = (state_q == WRITE);
  assign bus.refill_err    = refill_err_q;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.rd_data       = rd_word;

  assign rd_accept   = bus.rd_valid & bus.rd_ready;
  assign beat_accept = bus.refill_valid & bus.refill_ready;
  assign rd_index    = bus.rd_addr[OFFSET_W +: INDEX_W];
  assign beat_idx    = (state_q == IDLE) ? '0 : cnt_q;
  // A reset landing on the WRITE cycle must not commit the partial line.
  assign write_en    = (state_q == WRITE) && !rst;

  // Tag bits and the refill line offset play no part in the data array.
  assign unused_addr_bits = ^{bus.rd_addr[ADDR_W-1:OFFSET_W+INDEX_W],
                              bus.refill_addr[ADDR_W-1:OFFSET_W+INDEX_W],
                              bus.refill_addr[OFFSET_W-1:0]};

  // Refill FSM next-state: count beats and check RLAST against the expected count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    refill_err_d  = 1'b0;
    beat_is_final = (state_q == IDLE) ? (BEATS == 1)
                                      : (cnt_q == BEAT_IDX_W'(BEATS - 1));
    unique case (state_q)
      IDLE, FILL: begin
        if (beat_accept) begin
          refill_err_d = (bus.refill_last != beat_is_final);
          if (beat_is_final) begin
            state_d = WRITE;
            cnt_d   = '0;
          end else if (bus.refill_last) begin
            state_d = IDLE;          // early RLAST: discard the partial line
            cnt_d   = '0;
          end else begin
            state_d = FILL;
            cnt_d   = beat_idx + 1'b1;
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and read-side qualifiers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      refill_err_q    <= 1'b0;
      rd_data_valid_q <= 1'b0;
      hit_q           <= '0;
      off_q           <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      refill_err_q    <= refill_err_d;
      rd_data_valid_q <= rd_accept;
      if (rd_accept) begin
        hit_q <= bus.rd_hit;
        off_q <= bus.rd_addr[OFFSET_W-1:0];
      end
    end
  end

  // Line assembly: capture the victim location on the first beat and slot each beat.
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      line_buf_q[beat_idx] <= bus.refill_data;
      if (state_q == IDLE) begin
        fill_index_q <= bus.refill_addr[OFFSET_W +: INDEX_W];
        fill_way_q   <= bus.refill_way;
      end
    end
  end

  // Data array: single-cycle line commit and synchronous read of all ways.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays have no reset; contents must survive rst and a reset would bar RAM inference.
    if (write_en) begin
      mem[fill_way_q][fill_index_q] <= line_buf_q;
    end
    if (rd_accept) begin
      for (int w = 0; w < WAYS; w++) begin
        line_q[w] <= mem[w][rd_index];
      end
    end
  end

  if (OFFSET_W > 2) begin : g_word_idx
    assign word_idx = off_q[OFFSET_W-1:2];
  end else begin : g_word_idx_single
    assign word_idx = '0;
  end

  // Read mux: lowest hit way, aligned word only, zero on miss or misalignment.
  always_comb begin
    sel_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_q[w]) sel_way = WAY_W'(w);
    end
    sel_line = line_q[sel_way];
    rd_word  = '0;
    if ((hit_q != '0) && (off_q[1:0] == 2'b00)) begin
      rd_word = sel_line[word_idx];
    end
  end
endmodule
